// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the funct3 legality rule for loads and stores.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        READ1,
        READ2,
        WRITE,
        DONE
    } lsu_state_e;

    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: load extract/extend and sub-word store merge.
// The memory returns bytes starting at the access address, so only the low lanes matter.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    always_comb begin
        load_o = rdata_i;
        case (funct3_i)
            F3_B:    load_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
            F3_H:    load_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
            F3_BU:   load_o = {24'h0, rdata_i[7:0]};
            F3_HU:   load_o = {16'h0, rdata_i[15:0]};
            default: load_o = rdata_i;
        endcase
    end

    // Upper bytes keep their current memory contents for SB/SH.
    always_comb begin
        merge_o = wdata_i;
        case (funct3_i)
            F3_B:    merge_o = {rdata_i[31:8], wdata_i[7:0]};
            F3_H:    merge_o = {rdata_i[31:16], wdata_i[15:0]};
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one request at a time, two-cycle level read strobe,
// single-cycle write strobe, read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter bit ALIGN_CHK = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_r,
    output logic        mem_w
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'((2 ** ADDR_W) - 4);

    lsu_state_e  state_q, state_d;
    logic        err_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        misalign;
    logic        req_err;
    logic [31:0] load_word;
    logic [31:0] merge_word;

    assign accept = (state_q == IDLE) && req_valid;

    always_comb begin
        misalign = 1'b0;
        if (ALIGN_CHK) begin
            case (req_funct3[1:0])
                2'b01:   misalign = req_addr[0];
                2'b10:   misalign = |req_addr[1:0];
                default: misalign = 1'b0;
            endcase
        end
    end

    assign req_err = !is_legal(req_we, req_funct3)
                   || (|req_addr[31:ADDR_W])
                   || (req_addr[ADDR_W-1:0] > ADDR_MAX)
                   || misalign;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_d = DONE;
                    else if (req_we && (req_funct3 == F3_W))
                        state_d = WRITE;
                    else
                        state_d = READ1;
                end
            end
            READ1:   state_d = READ2;
            READ2:   state_d = we_q ? WRITE : DONE;
            WRITE:   state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept)
                err_q <= req_err;
        end
    end

    // Request and read-word latches carry no reset; every output that shows them is gated by state.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
        if (state_q == READ2)
            rdata_q <= mem_rdata;
    end

    lsu_align u_align (
        .funct3_i (f3_q),
        .rdata_i  (rdata_q),
        .wdata_i  (wdata_q),
        .load_o   (load_word),
        .merge_o  (merge_word)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? load_word : 32'h0;
    assign mem_r     = (state_q == READ1) || (state_q == READ2);
    assign mem_w     = (state_q == WRITE);
    assign mem_addr  = (state_q == IDLE) ? 32'h0 : addr_q;
    assign mem_wdata = mem_w ? merge_word : 32'h0;

endmodule
